// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage -- RV32I instruction decode pipeline stage
//
// Captures the fetched instruction into an IF/ID register, decodes it, reads the
// 32x32 register file, and registers operands, immediate and control into an
// ID/EX register for the execute stage. Also owns the register-file write port
// driven from writeback.
//
// Stage control contract (there is no valid/ready handshake here):
//   flush_decode : IF/ID <- NOP (valid=0), ID/EX <- bubble. Wins over stall.
//   stall_decode : IF/ID holds, ID/EX <- bubble.
//   otherwise    : IF/ID <- fetch outputs (valid=1), ID/EX <- decode results,
//                  or a bubble when IF/ID holds no valid instruction.
//
// Configuration macro: DECODE_RF_BYPASS_EN
//   defined   : register-file reads see a same-cycle writeback (write-through).
//   undefined : same-cycle reads return the stale value; the hazard unit stalls.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   stall_decode, flush_decode   hazard / redirect control
//   instruction_fetch, pc_fetch, next_pc_fetch   fetch stage outputs
//   reg_write_wb, rd_wb, result_wb               writeback write port
//   *_execute                    ID/EX register outputs consumed by execute
// -----------------------------------------------------------------------------
module decode_stage #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_decode,
  input  logic            flush_decode,
  input  logic [31:0]     instruction_fetch,
  input  logic [XLEN-1:0] pc_fetch,
  input  logic [XLEN-1:0] next_pc_fetch,
  input  logic            reg_write_wb,
  input  logic [4:0]      rd_wb,
  input  logic [XLEN-1:0] result_wb,
  output logic [XLEN-1:0] pc_execute,
  output logic [XLEN-1:0] next_pc_execute,
  output logic [XLEN-1:0] rs1_data_execute,
  output logic [XLEN-1:0] rs2_data_execute,
  output logic [XLEN-1:0] imm_execute,
  output logic [4:0]      rs1_execute,
  output logic [4:0]      rs2_execute,
  output logic [4:0]      rd_execute,
  output logic [3:0]      alu_control_execute,
  output logic            alu_src_execute,
  output logic            alu_a_pc_execute,
  output logic [1:0]      result_src_execute,
  output logic            reg_write_execute,
  output logic            mem_write_execute,
  output logic            branch_execute,
  output logic            jump_execute,
  output logic [2:0]      funct3_execute,
  output logic            valid_execute,
  output logic            illegal_execute
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  // ---------------------------------------------------------------------------
  // IF/ID register
  // ---------------------------------------------------------------------------
  logic [31:0]     r_if_instr;
  logic [XLEN-1:0] r_if_pc;
  logic [XLEN-1:0] r_if_next_pc;
  logic            r_if_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_if_instr   <= NOP_INSTR;
      r_if_pc      <= '0;
      r_if_next_pc <= '0;
      r_if_valid   <= 1'b0;
    end else if (flush_decode) begin
      r_if_instr   <= NOP_INSTR;
      r_if_pc      <= '0;
      r_if_next_pc <= '0;
      r_if_valid   <= 1'b0;
    end else if (!stall_decode) begin
      r_if_instr   <= instruction_fetch;
      r_if_pc      <= pc_fetch;
      r_if_next_pc <= next_pc_fetch;
      r_if_valid   <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Instruction fields
  // ---------------------------------------------------------------------------
  logic [6:0] w_opcode;
  logic [4:0] w_rd;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic [2:0] w_funct3;
  logic       w_funct7_b5;

  assign w_opcode    = r_if_instr[6:0];
  assign w_rd        = r_if_instr[11:7];
  assign w_funct3    = r_if_instr[14:12];
  assign w_rs1       = r_if_instr[19:15];
  assign w_rs2       = r_if_instr[24:20];
  assign w_funct7_b5 = r_if_instr[30];

  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;

  assign w_imm_i = {{20{r_if_instr[31]}}, r_if_instr[31:20]};
  assign w_imm_s = {{20{r_if_instr[31]}}, r_if_instr[31:25], r_if_instr[11:7]};
  assign w_imm_b = {{19{r_if_instr[31]}}, r_if_instr[31], r_if_instr[7],
                    r_if_instr[30:25], r_if_instr[11:8], 1'b0};
  assign w_imm_u = {r_if_instr[31:12], 12'b0};
  assign w_imm_j = {{11{r_if_instr[31]}}, r_if_instr[31], r_if_instr[19:12],
                    r_if_instr[20], r_if_instr[30:21], 1'b0};

  // funct3 -> ALU op for register and immediate arithmetic. use_sub selects SUB
  // on funct3=000, which only R-type is allowed to do; funct7[5] always picks
  // SRA over SRL.
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3,
                                                 input logic       f7_b5,
                                                 input logic       use_sub);
    logic [3:0] op;
    op = ALU_ADD;
    case (f3)
      3'b000:  op = (use_sub && f7_b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7_b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // ---------------------------------------------------------------------------
  // Decoder
  // ---------------------------------------------------------------------------
  logic [3:0]  w_alu_control;
  logic        w_alu_src;
  logic        w_alu_a_pc;
  logic [1:0]  w_result_src;
  logic        w_reg_write;
  logic        w_mem_write;
  logic        w_branch;
  logic        w_jump;
  logic        w_illegal;
  logic [31:0] w_imm;

  always_comb begin
    w_alu_control = ALU_ADD;
    w_alu_src     = 1'b0;
    w_alu_a_pc    = 1'b0;
    w_result_src  = 2'b00;
    w_reg_write   = 1'b0;
    w_mem_write   = 1'b0;
    w_branch      = 1'b0;
    w_jump        = 1'b0;
    w_illegal     = 1'b0;
    w_imm         = 32'b0;
    case (w_opcode)
      OP_R: begin
        w_alu_control = alu_from_funct3(w_funct3, w_funct7_b5, 1'b1);
        w_reg_write   = 1'b1;
      end
      OP_I_ALU: begin
        w_alu_control = alu_from_funct3(w_funct3, w_funct7_b5, 1'b0);
        w_alu_src     = 1'b1;
        w_reg_write   = 1'b1;
        w_imm         = w_imm_i;
      end
      OP_LOAD: begin
        w_alu_src    = 1'b1;
        w_reg_write  = 1'b1;
        w_result_src = 2'b01;
        w_imm        = w_imm_i;
      end
      OP_STORE: begin
        w_alu_src   = 1'b1;
        w_mem_write = 1'b1;
        w_imm       = w_imm_s;
      end
      OP_BRANCH: begin
        // Condition is resolved in execute from funct3; SUB suits the compare.
        w_alu_control = ALU_SUB;
        w_branch      = 1'b1;
        w_imm         = w_imm_b;
      end
      OP_JAL: begin
        // ALU forms the target as PC + imm; rd receives next PC.
        w_alu_a_pc   = 1'b1;
        w_alu_src    = 1'b1;
        w_jump       = 1'b1;
        w_reg_write  = 1'b1;
        w_result_src = 2'b10;
        w_imm        = w_imm_j;
      end
      OP_JALR: begin
        w_alu_src    = 1'b1;
        w_jump       = 1'b1;
        w_reg_write  = 1'b1;
        w_result_src = 2'b10;
        w_imm        = w_imm_i;
      end
      OP_LUI: begin
        w_alu_control = ALU_PASSB;
        w_alu_src     = 1'b1;
        w_reg_write   = 1'b1;
        w_imm         = w_imm_u;
      end
      OP_AUIPC: begin
        w_alu_a_pc  = 1'b1;
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
        w_imm       = w_imm_u;
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Register file: x0 is never written and always reads 0.
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] r_rf [32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else if (reg_write_wb && (rd_wb != 5'd0)) begin
      r_rf[rd_wb] <= result_wb;
    end
  end

  logic [XLEN-1:0] w_rs1_data;
  logic [XLEN-1:0] w_rs2_data;

`ifdef DECODE_RF_BYPASS_EN
  logic w_byp_rs1;
  logic w_byp_rs2;
  assign w_byp_rs1 = reg_write_wb && (rd_wb != 5'd0) && (rd_wb == w_rs1);
  assign w_byp_rs2 = reg_write_wb && (rd_wb != 5'd0) && (rd_wb == w_rs2);
  assign w_rs1_data = (w_rs1 == 5'd0) ? '0 : (w_byp_rs1 ? result_wb : r_rf[w_rs1]);
  assign w_rs2_data = (w_rs2 == 5'd0) ? '0 : (w_byp_rs2 ? result_wb : r_rf[w_rs2]);
`else
  assign w_rs1_data = (w_rs1 == 5'd0) ? '0 : r_rf[w_rs1];
  assign w_rs2_data = (w_rs2 == 5'd0) ? '0 : r_rf[w_rs2];
`endif

  // ---------------------------------------------------------------------------
  // ID/EX register. A bubble zeroes every field so the register is fully
  // deterministic, not just the enables.
  // ---------------------------------------------------------------------------
  logic w_bubble;
  assign w_bubble = stall_decode || flush_decode || !r_if_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst || w_bubble) begin
      pc_execute          <= '0;
      next_pc_execute     <= '0;
      rs1_data_execute    <= '0;
      rs2_data_execute    <= '0;
      imm_execute         <= '0;
      rs1_execute         <= '0;
      rs2_execute         <= '0;
      rd_execute          <= '0;
      alu_control_execute <= '0;
      alu_src_execute     <= 1'b0;
      alu_a_pc_execute    <= 1'b0;
      result_src_execute  <= '0;
      reg_write_execute   <= 1'b0;
      mem_write_execute   <= 1'b0;
      branch_execute      <= 1'b0;
      jump_execute        <= 1'b0;
      funct3_execute      <= '0;
      valid_execute       <= 1'b0;
      illegal_execute     <= 1'b0;
    end else begin
      pc_execute          <= r_if_pc;
      next_pc_execute     <= r_if_next_pc;
      rs1_data_execute    <= w_rs1_data;
      rs2_data_execute    <= w_rs2_data;
      imm_execute         <= w_imm;
      rs1_execute         <= w_rs1;
      rs2_execute         <= w_rs2;
      rd_execute          <= w_rd;
      alu_control_execute <= w_alu_control;
      alu_src_execute     <= w_alu_src;
      alu_a_pc_execute    <= w_alu_a_pc;
      result_src_execute  <= w_result_src;
      reg_write_execute   <= w_reg_write;
      mem_write_execute   <= w_mem_write;
      branch_execute      <= w_branch;
      jump_execute        <= w_jump;
      funct3_execute      <= w_funct3;
      valid_execute       <= 1'b1;
      illegal_execute     <= w_illegal;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage -- directed self-checking bench for decode_stage.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_decode;
  logic        flush_decode;
  logic [31:0] instruction_fetch;
  logic [31:0] pc_fetch;
  logic [31:0] next_pc_fetch;
  logic        reg_write_wb;
  logic [4:0]  rd_wb;
  logic [31:0] result_wb;
  logic [31:0] pc_execute;
  logic [31:0] next_pc_execute;
  logic [31:0] rs1_data_execute;
  logic [31:0] rs2_data_execute;
  logic [31:0] imm_execute;
  logic [4:0]  rs1_execute;
  logic [4:0]  rs2_execute;
  logic [4:0]  rd_execute;
  logic [3:0]  alu_control_execute;
  logic        alu_src_execute;
  logic        alu_a_pc_execute;
  logic [1:0]  result_src_execute;
  logic        reg_write_execute;
  logic        mem_write_execute;
  logic        branch_execute;
  logic        jump_execute;
  logic [2:0]  funct3_execute;
  logic        valid_execute;
  logic        illegal_execute;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] NOP = 32'h00000013;

  decode_stage dut (
    .clk                 (clk),
    .rst                 (rst),
    .stall_decode        (stall_decode),
    .flush_decode        (flush_decode),
    .instruction_fetch   (instruction_fetch),
    .pc_fetch            (pc_fetch),
    .next_pc_fetch       (next_pc_fetch),
    .reg_write_wb        (reg_write_wb),
    .rd_wb               (rd_wb),
    .result_wb           (result_wb),
    .pc_execute          (pc_execute),
    .next_pc_execute     (next_pc_execute),
    .rs1_data_execute    (rs1_data_execute),
    .rs2_data_execute    (rs2_data_execute),
    .imm_execute         (imm_execute),
    .rs1_execute         (rs1_execute),
    .rs2_execute         (rs2_execute),
    .rd_execute          (rd_execute),
    .alu_control_execute (alu_control_execute),
    .alu_src_execute     (alu_src_execute),
    .alu_a_pc_execute    (alu_a_pc_execute),
    .result_src_execute  (result_src_execute),
    .reg_write_execute   (reg_write_execute),
    .mem_write_execute   (mem_write_execute),
    .branch_execute      (branch_execute),
    .jump_execute        (jump_execute),
    .funct3_execute      (funct3_execute),
    .valid_execute       (valid_execute),
    .illegal_execute     (illegal_execute)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fetch(input logic [31:0] instr, input logic [31:0] pc);
    instruction_fetch = instr;
    pc_fetch          = pc;
    next_pc_fetch     = pc + 32'd4;
  endtask

  // Present an instruction and let it reach ID/EX (two edges).
  task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
    set_fetch(instr, pc);
    tick();
    tick();
  endtask

  task automatic wb_write(input logic [4:0] rd, input logic [31:0] data);
    reg_write_wb = 1'b1;
    rd_wb        = rd;
    result_wb    = data;
    tick();
    reg_write_wb = 1'b0;
    rd_wb        = 5'd0;
    result_wb    = 32'd0;
  endtask

  // ---------------------------------------------------------------------------
  // Comparison point
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  logic [31:0] exp_byp;

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst          = 1'b1;
    stall_decode = 1'b0;
    flush_decode = 1'b0;
    reg_write_wb = 1'b0;
    rd_wb        = 5'd0;
    result_wb    = 32'd0;
    set_fetch(NOP, 32'd0);
    tick();
    tick();

    // Reset state
    chk("rst_valid",     {31'd0, valid_execute},     32'd0);
    chk("rst_pc",        pc_execute,                 32'd0);
    chk("rst_imm",       imm_execute,                32'd0);
    chk("rst_reg_write", {31'd0, reg_write_execute}, 32'd0);

    // First instruction after reset: addi x1,x0,5 two edges after rst falls
    set_fetch(32'h00500093, 32'h0);
    rst = 1'b0;
    tick();
    tick();
    chk("addi_valid",     {31'd0, valid_execute},       32'd1);
    chk("addi_rd",        {27'd0, rd_execute},          32'd1);
    chk("addi_imm",       imm_execute,                  32'd5);
    chk("addi_alu_src",   {31'd0, alu_src_execute},     32'd1);
    chk("addi_reg_write", {31'd0, reg_write_execute},   32'd1);
    chk("addi_alu",       {28'd0, alu_control_execute}, 32'd0);

    // Asynchronous reset mid-stream while stalled
    stall_decode = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, valid_execute}, 32'd0);
    chk("arst_rd",    {27'd0, rd_execute},    32'd0);
    chk("arst_imm",   imm_execute,            32'd0);
    stall_decode = 1'b0;
    tick();
    rst = 1'b0;

    // Writeback x1=5, x2=7; a write to x0 must be dropped
    wb_write(5'd1, 32'd5);
    wb_write(5'd2, 32'd7);
    wb_write(5'd0, 32'hFFFF);

    issue(32'h002081B3, 32'h10);   // add x3,x1,x2
    chk("add_rs1_data", rs1_data_execute,             32'd5);
    chk("add_rs2_data", rs2_data_execute,             32'd7);
    chk("add_alu",      {28'd0, alu_control_execute}, 32'd0);
    chk("add_rd",       {27'd0, rd_execute},          32'd3);
    chk("add_rs1",      {27'd0, rs1_execute},         32'd1);
    chk("add_rs2",      {27'd0, rs2_execute},         32'd2);
    chk("add_pc",       pc_execute,                   32'h10);

    issue(32'h40208233, 32'h14);   // sub x4,x1,x2
    chk("sub_alu", {28'd0, alu_control_execute}, 32'd1);

    issue(32'h00500093, 32'h18);   // addi x1,x0,5 : x0 reads zero
    chk("x0_read", rs1_data_execute, 32'd0);

    issue(32'h0020A423, 32'h1C);   // sw x2,8(x1)
    chk("sw_imm",       imm_execute,                 32'd8);
    chk("sw_mem_write", {31'd0, mem_write_execute},  32'd1);
    chk("sw_reg_write", {31'd0, reg_write_execute},  32'd0);
    chk("sw_rs2_data",  rs2_data_execute,            32'd7);
    chk("sw_funct3",    {29'd0, funct3_execute},     32'd2);

    issue(32'h123452B7, 32'h20);   // lui x5,0x12345
    chk("lui_imm", imm_execute,                  32'h12345000);
    chk("lui_alu", {28'd0, alu_control_execute}, 32'd10);
    chk("lui_rd",  {27'd0, rd_execute},          32'd5);

    issue(32'hFFF00313, 32'h24);   // addi x6,x0,-1
    chk("neg_imm", imm_execute, 32'hFFFFFFFF);

    issue(32'hFE208EE3, 32'h28);   // beq x1,x2,-4
    chk("beq_imm",       imm_execute,                32'hFFFFFFFC);
    chk("beq_branch",    {31'd0, branch_execute},    32'd1);
    chk("beq_reg_write", {31'd0, reg_write_execute}, 32'd0);

    issue(32'h010000EF, 32'h100);  // jal x1,16
    chk("jal_imm",        imm_execute,                32'd16);
    chk("jal_jump",       {31'd0, jump_execute},      32'd1);
    chk("jal_result_src", {30'd0, result_src_execute}, 32'd2);
    chk("jal_next_pc",    next_pc_execute,            32'h104);
    chk("jal_pc",         pc_execute,                 32'h100);
    chk("jal_reg_write",  {31'd0, reg_write_execute}, 32'd1);

    // Stall for two cycles: two bubbles, then the held instruction
    set_fetch(32'h00500093, 32'h200);   // A: addi x1,x0,5
    tick();                             // IF/ID <- A
    stall_decode = 1'b1;
    set_fetch(32'h123452B7, 32'h204);   // B: lui x5 waits at fetch
    tick();
    chk("stall_bubble1", {31'd0, valid_execute}, 32'd0);
    tick();
    chk("stall_bubble2", {31'd0, valid_execute}, 32'd0);
    chk("stall_bubble2_rw", {31'd0, reg_write_execute}, 32'd0);
    stall_decode = 1'b0;
    tick();
    chk("stall_held_valid", {31'd0, valid_execute}, 32'd1);
    chk("stall_held_rd",    {27'd0, rd_execute},    32'd1);
    chk("stall_held_pc",    pc_execute,             32'h200);
    tick();
    chk("stall_next_rd",    {27'd0, rd_execute},    32'd5);

    // Stall and flush together: flush wins, both registers bubble
    stall_decode = 1'b1;
    flush_decode = 1'b1;
    set_fetch(32'h00500093, 32'h300);
    tick();
    chk("sf_valid",     {31'd0, valid_execute},     32'd0);
    chk("sf_reg_write", {31'd0, reg_write_execute}, 32'd0);
    stall_decode = 1'b0;
    flush_decode = 1'b0;
    tick();                              // IF/ID was flushed -> still a bubble
    chk("sf_ifid_bubble", {31'd0, valid_execute}, 32'd0);
    tick();
    chk("sf_resume_valid", {31'd0, valid_execute}, 32'd1);
    chk("sf_resume_pc",    pc_execute,             32'h300);

    // Illegal opcode
    issue(32'hFFFFFFFF, 32'h400);
    chk("ill_illegal",   {31'd0, illegal_execute},   32'd1);
    chk("ill_valid",     {31'd0, valid_execute},     32'd1);
    chk("ill_reg_write", {31'd0, reg_write_execute}, 32'd0);
    chk("ill_mem_write", {31'd0, mem_write_execute}, 32'd0);
    chk("ill_branch",    {31'd0, branch_execute},    32'd0);
    chk("ill_jump",      {31'd0, jump_execute},      32'd0);

    // Same-cycle writeback and read of x4
    set_fetch(32'h00020513, 32'h500);   // addi x10,x4,0
    tick();                             // IF/ID <- addi x10,x4,0
    reg_write_wb = 1'b1;
    rd_wb        = 5'd4;
    result_wb    = 32'h0000DEAD;
`ifdef DECODE_RF_BYPASS_EN
    exp_byp = 32'h0000DEAD;
`else
    exp_byp = 32'h0;
`endif
    tick();
    reg_write_wb = 1'b0;
    rd_wb        = 5'd0;
    result_wb    = 32'd0;
    chk("bypass_rs1_data", rs1_data_execute, exp_byp);
    tick();
    chk("after_wb_rs1_data", rs1_data_execute, 32'h0000DEAD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
